// File: rtl/trig_rst_sequencer_if.sv
// Bundle between the trigger/reset sequencer and its environment.
// The trigger comes in on this bundle, and the staged resets and status signals go out on it.
interface trig_rst_sequencer_if #(
  parameter int STAGES = 3
);
  logic              TrigIn;
  logic [STAGES-1:0] RstOut;
  logic              Ready;
  logic              LedStat;

  modport master (
    output TrigIn,
    input  RstOut,
    input  Ready,
    input  LedStat
  );

  modport slave (
    input  TrigIn,
    output RstOut,
    output Ready,
    output LedStat
  );
endinterface

// File: rtl/trig_rst_sequencer.sv
// Synchronises and width-qualifies an active-low trigger.
// It then releases STAGES active-low resets one after another, and runs a heartbeat LED once all are out.
module trig_rst_sequencer #(
  parameter int MIN_LOW   = 4,
  parameter int STAGES    = 3,
  parameter int STAGE_DLY = 50000,
  parameter int LED_DIV   = 25000000
) (
  input logic                  CLK,
  input logic                  RstBtn,
  trig_rst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_TRIG = 2'd0,
    ARMED     = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [31:0] MIN_LOW_C = 32'(MIN_LOW);
  localparam logic [31:0] DLY_TC    = 32'(STAGE_DLY - 1);
  localparam logic [31:0] LED_TC    = 32'(LED_DIV - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(STAGES - 1);

  function automatic logic [STAGES-1:0] stage_mask(input logic [2:0] idx);
    logic [STAGES-1:0] m;
    for (int k = 0; k < STAGES; k++) begin
      m[k] = (idx == 3'(k));
    end
    return m;
  endfunction

  state_t            state_r, state_nxt;
  logic [1:0]        sync_r;
  logic [31:0]       low_cnt_r;
  logic [31:0]       dly_r, dly_nxt;
  logic [31:0]       led_cnt_r, led_cnt_nxt;
  logic [2:0]        idx_r, idx_nxt;
  logic [STAGES-1:0] rst_out_r, rst_out_nxt;
  logic              ready_r, ready_nxt;
  logic              led_r, led_nxt;
  logic              trs_s;
  logic              vlow_s;

  assign trs_s  = sync_r[1];
  assign vlow_s = (low_cnt_r == MIN_LOW_C);

  // Two-flop synchroniser for the asynchronous trigger pin, idling high
  always_ff @(posedge CLK or negedge RstBtn) begin
    if (!RstBtn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.TrigIn};
    end
  end

  // Width qualifier: saturating count of consecutive synchronised-low cycles
  always_ff @(posedge CLK or negedge RstBtn) begin
    if (!RstBtn) begin
      low_cnt_r <= 32'd0;
    end else if (trs_s) begin
      low_cnt_r <= 32'd0;
    end else if (low_cnt_r == MIN_LOW_C) begin
      low_cnt_r <= low_cnt_r;
    end else begin
      low_cnt_r <= low_cnt_r + 32'd1;
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge CLK or negedge RstBtn) begin
    if (!RstBtn) begin
      state_r   <= WAIT_TRIG;
      dly_r     <= 32'd0;
      led_cnt_r <= 32'd0;
      idx_r     <= 3'd0;
      rst_out_r <= {STAGES{1'b0}};
      ready_r   <= 1'b0;
      led_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      dly_r     <= dly_nxt;
      led_cnt_r <= led_cnt_nxt;
      idx_r     <= idx_nxt;
      rst_out_r <= rst_out_nxt;
      ready_r   <= ready_nxt;
      led_r     <= led_nxt;
    end
  end

  // Next-state and next-output logic; a qualified low while sequencing or running re-arms
  always_comb begin
    state_nxt   = state_r;
    dly_nxt     = dly_r;
    led_cnt_nxt = led_cnt_r;
    idx_nxt     = idx_r;
    rst_out_nxt = rst_out_r;
    ready_nxt   = ready_r;
    led_nxt     = led_r;
    if (vlow_s && ((state_r == RELEASE) || (state_r == RUN))) begin
      state_nxt   = ARMED;
      dly_nxt     = 32'd0;
      led_cnt_nxt = 32'd0;
      idx_nxt     = 3'd0;
      rst_out_nxt = {STAGES{1'b0}};
      ready_nxt   = 1'b0;
      led_nxt     = 1'b0;
    end else begin
      case (state_r)
        WAIT_TRIG: begin
          rst_out_nxt = {STAGES{1'b0}};
          ready_nxt   = 1'b0;
          led_nxt     = 1'b0;
          if (vlow_s) begin
            state_nxt = ARMED;
          end else begin
            state_nxt = WAIT_TRIG;
          end
        end
        ARMED: begin
          rst_out_nxt = {STAGES{1'b0}};
          ready_nxt   = 1'b0;
          led_nxt     = 1'b0;
          if (trs_s) begin
            state_nxt = RELEASE;
            dly_nxt   = 32'd0;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = ARMED;
          end
        end
        RELEASE: begin
          if (dly_r == DLY_TC) begin
            rst_out_nxt = rst_out_r | stage_mask(idx_r);
            dly_nxt     = 32'd0;
            idx_nxt     = idx_r + 3'd1;
            if (idx_r == LAST_IDX) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end else begin
              state_nxt = RELEASE;
            end
          end else begin
            dly_nxt = dly_r + 32'd1;
          end
        end
        RUN: begin
          ready_nxt = 1'b1;
          if (led_cnt_r == LED_TC) begin
            led_cnt_nxt = 32'd0;
            led_nxt     = ~led_r;
          end else begin
            led_cnt_nxt = led_cnt_r + 32'd1;
          end
        end
        default: begin
          state_nxt   = WAIT_TRIG;
          dly_nxt     = 32'd0;
          led_cnt_nxt = 32'd0;
          idx_nxt     = 3'd0;
          rst_out_nxt = {STAGES{1'b0}};
          ready_nxt   = 1'b0;
          led_nxt     = 1'b0;
        end
      endcase
    end
  end

  assign bus.RstOut  = rst_out_r;
  assign bus.Ready   = ready_r;
  assign bus.LedStat = led_r;

endmodule
